// File: rtl/uart_sched_pkg.sv
// Shared state encoding and constants for the UART transmit scheduler.
package uart_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARB  = 3'd1,
    ST_HDR  = 3'd2,
    ST_LOAD = 3'd3,
    ST_WAIT = 3'd4
  } sched_state_e;

  localparam logic [7:0] HEADER_BASE_DEFAULT = 8'hA0;
  localparam int         TO_CNT_W            = 16;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Rotate-priority encoder: first set request strictly after ptr, wrapping.
module uart_rr_arbiter
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  // Scan ptr+1, ptr+2, ... with wrap; the first valid candidate wins.
  always_comb begin
    logic [IDX_W-1:0] cand_s;
    gnt    = '0;
    idx    = '0;
    any    = 1'b0;
    cand_s = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_s = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (!any && req[cand_s]) begin
        any         = 1'b1;
        gnt[cand_s] = 1'b1;
        idx         = cand_s;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Packet-level round-robin scheduler sharing one uart_tx between requesters,
// with an optional channel-ID header byte ahead of each packet.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int                         NUM_REQ         = 4,
  parameter int                         UART_DATA_WIDTH = 8,
  parameter int                         ID_HEADER       = 1,
  parameter logic [UART_DATA_WIDTH-1:0] HEADER_BASE     = HEADER_BASE_DEFAULT,
  parameter int                         TIMEOUT         = 1024
) (
  input  logic                               i_Clock,
  input  logic                               i_Reset,
  input  logic [NUM_REQ-1:0]                 i_Req_Valid,
  input  logic [NUM_REQ*UART_DATA_WIDTH-1:0] i_Req_Data,
  input  logic [NUM_REQ-1:0]                 i_Req_Last,
  output logic [NUM_REQ-1:0]                 o_Req_Ready,
  output logic                               o_Tx_DV,
  output logic [UART_DATA_WIDTH-1:0]         o_Tx_Byte,
  input  logic                               i_Tx_Active,
  input  logic                               i_Tx_Done,
  output logic [NUM_REQ-1:0]                 o_Grant,
  output logic                               o_Abort
);

  localparam int                  IDX_W   = idx_width(NUM_REQ);
  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT - 1);

  sched_state_e                 state_r, state_s;
  logic                         dv_r, dv_s;
  logic [UART_DATA_WIDTH-1:0]   byte_r, byte_s;
  logic [NUM_REQ-1:0]           grant_r, grant_s;
  logic [IDX_W-1:0]             gidx_r, gidx_s;
  logic [IDX_W-1:0]             ptr_r, ptr_s;
  logic                         abort_r, abort_s;
  logic                         last_r, last_s;
  logic [TO_CNT_W-1:0]          cnt_r, cnt_s;
  logic                         done_q_r;
  logic                         done_rise_s;
  logic                         sel_valid_s;
  logic                         sel_last_s;
  logic [UART_DATA_WIDTH-1:0]   sel_data_s;
  logic [NUM_REQ-1:0]           arb_gnt_s;
  logic [IDX_W-1:0]             arb_idx_s;
  logic                         arb_any_s;

  uart_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req (i_Req_Valid),
    .ptr (ptr_r),
    .gnt (arb_gnt_s),
    .idx (arb_idx_s),
    .any (arb_any_s)
  );

  // Only the first cycle of the two-cycle done pulse advances the packet.
  assign done_rise_s = i_Tx_Done & ~done_q_r;
  assign sel_valid_s = i_Req_Valid[gidx_r];
  assign sel_last_s  = i_Req_Last[gidx_r];
  assign sel_data_s  = i_Req_Data[gidx_r * UART_DATA_WIDTH +: UART_DATA_WIDTH];

  assign o_Tx_DV   = dv_r;
  assign o_Tx_Byte = byte_r;
  assign o_Grant   = grant_r;
  assign o_Abort   = abort_r;

  // Ready is offered only to the owner, and only while waiting for its next byte.
  always_comb begin
    if (state_r == ST_LOAD) begin
      o_Req_Ready = grant_r & i_Req_Valid;
    end else begin
      o_Req_Ready = '0;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s = state_r;
    dv_s    = 1'b0;
    byte_s  = byte_r;
    grant_s = grant_r;
    gidx_s  = gidx_r;
    ptr_s   = ptr_r;
    abort_s = 1'b0;
    last_s  = last_r;
    cnt_s   = '0;
    case (state_r)
      ST_IDLE: begin
        // Never start while the serializer may still be finishing a byte.
        if (!i_Tx_Active && !i_Tx_Done && (|i_Req_Valid)) begin
          state_s = ST_ARB;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ARB: begin
        if (arb_any_s) begin
          grant_s = arb_gnt_s;
          gidx_s  = arb_idx_s;
          if (ID_HEADER != 0) begin
            state_s = ST_HDR;
          end else begin
            state_s = ST_LOAD;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_HDR: begin
        byte_s  = HEADER_BASE | UART_DATA_WIDTH'(gidx_r);
        dv_s    = 1'b1;
        last_s  = 1'b0;
        state_s = ST_WAIT;
      end
      ST_LOAD: begin
        if (sel_valid_s) begin
          byte_s  = sel_data_s;
          last_s  = sel_last_s;
          dv_s    = 1'b1;
          state_s = ST_WAIT;
        end else if ((TIMEOUT != 0) && (cnt_r == TO_LAST)) begin
          abort_s = 1'b1;
          ptr_s   = gidx_r;
          grant_s = '0;
          state_s = ST_IDLE;
        end else begin
          cnt_s = cnt_r + TO_CNT_W'(1'b1);
        end
      end
      ST_WAIT: begin
        if (done_rise_s) begin
          if (last_r) begin
            ptr_s   = gidx_r;
            grant_s = '0;
            state_s = ST_IDLE;
          end else begin
            state_s = ST_LOAD;
          end
        end else begin
          state_s = ST_WAIT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_r  <= ST_IDLE;
      dv_r     <= 1'b0;
      byte_r   <= '0;
      grant_r  <= '0;
      gidx_r   <= '0;
      ptr_r    <= IDX_W'(NUM_REQ - 1);
      abort_r  <= 1'b0;
      last_r   <= 1'b0;
      cnt_r    <= '0;
      done_q_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      dv_r     <= dv_s;
      byte_r   <= byte_s;
      grant_r  <= grant_s;
      gidx_r   <= gidx_s;
      ptr_r    <= ptr_s;
      abort_r  <= abort_s;
      last_r   <= last_s;
      cnt_r    <= cnt_s;
      done_q_r <= i_Tx_Done;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench: instance 0 sends header bytes, instance 1 does not;
// a behavioural uart_tx model on each instance drives active/done.
module tb_uart_tx_scheduler;

  localparam int ACT_CYC = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  rv  [2] = '{4'h0, 4'h0};
  logic [31:0] rd  [2] = '{32'h0, 32'h0};
  logic [3:0]  rl  [2] = '{4'h0, 4'h0};
  logic [3:0]  rr  [2];
  logic [1:0]  dv;
  logic [7:0]  txb [2];
  logic [1:0]  act = 2'b00;
  logic [1:0]  dn  = 2'b00;
  logic [3:0]  gnt [2];
  logic [1:0]  abt;

  int          checks = 0;
  int          failures = 0;
  logic [8:0]  rq [8][$];
  logic [11:0] eq [2][$];
  logic [3:0]  hs [2] = '{4'h0, 4'h0};
  logic [1:0]  busy = 2'b00;
  int          cnt_m [2] = '{0, 0};
  logic [7:0]  cap [2];
  int          cyc = 0;
  int          rise_cyc [2] = '{0, 0};
  int          dv_cnt [2] = '{0, 0};
  int          abort_cnt [2] = '{0, 0};
  int          abort_gap = 0;
  logic        gap_armed = 1'b0;
  logic [11:0] mon_e;

  always #5 clk = ~clk;

  uart_tx_scheduler #(
    .NUM_REQ(4), .UART_DATA_WIDTH(8), .ID_HEADER(1), .HEADER_BASE(8'hA0), .TIMEOUT(1024)
  ) u_dut (
    .i_Clock(clk), .i_Reset(rst), .i_Req_Valid(rv[0]), .i_Req_Data(rd[0]),
    .i_Req_Last(rl[0]), .o_Req_Ready(rr[0]), .o_Tx_DV(dv[0]), .o_Tx_Byte(txb[0]),
    .i_Tx_Active(act[0]), .i_Tx_Done(dn[0]), .o_Grant(gnt[0]), .o_Abort(abt[0])
  );

  uart_tx_scheduler #(
    .NUM_REQ(4), .UART_DATA_WIDTH(8), .ID_HEADER(0), .HEADER_BASE(8'hA0), .TIMEOUT(1024)
  ) u_dut_nohdr (
    .i_Clock(clk), .i_Reset(rst), .i_Req_Valid(rv[1]), .i_Req_Data(rd[1]),
    .i_Req_Last(rl[1]), .o_Req_Ready(rr[1]), .o_Tx_DV(dv[1]), .o_Tx_Byte(txb[1]),
    .i_Tx_Active(act[1]), .i_Tx_Done(dn[1]), .o_Grant(gnt[1]), .o_Abort(abt[1])
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic send(input int g, input int k, input logic [7:0] b, input logic last);
    rq[g*4+k].push_back({last, b});
  endtask

  task automatic exp_tx(input int g, input logic [3:0] gr, input logic [7:0] b);
    eq[g].push_back({gr, b});
  endtask

  function automatic bit q_empty(input int g);
    for (int k = 0; k < 4; k++) begin
      if (rq[g*4+k].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic wait_idle(input int g, input int budget, input string name);
    int n;
    n = 0;
    while (n < budget && !(eq[g].size() == 0 && !busy[g] && gnt[g] == 4'h0 && q_empty(g))) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(n < budget), 32'd1);
  endtask

  // Handshakes complete on the rising edge; the driver retires them afterwards.
  always @(posedge clk) begin
    hs[0] <= rr[0] & rv[0];
    hs[1] <= rr[1] & rv[1];
  end

  // uart_tx model, scoreboard monitor and requester drivers, all on the falling edge.
  always @(negedge clk) begin
    cyc++;
    for (int g = 0; g < 2; g++) begin
      if (busy[g]) begin
        cnt_m[g]++;
        if (cnt_m[g] == ACT_CYC) begin
          act[g] = 1'b0;
          dn[g] = 1'b1;
          rise_cyc[g] = cyc;
        end else if (cnt_m[g] == ACT_CYC + 2) begin
          dn[g] = 1'b0;
          busy[g] = 1'b0;
        end
      end
      if (busy[g] && act[g] && !dv[g] && gnt[g] != 4'h0) chk("byte_stable", 32'(txb[g]), 32'(cap[g]));
      chk("ready_owner_only", 32'(rr[g] & ~gnt[g]), 32'd0);
      if (abt[g]) begin
        abort_cnt[g]++;
        abort_gap = cyc - rise_cyc[g];
        chk("grant_at_abort", 32'(gnt[g]), 32'd0);
      end
      if (dv[g]) begin
        dv_cnt[g]++;
        chk("dv_while_busy", 32'(busy[g]), 32'd0);
        chk("dv_expected", 32'(eq[g].size() != 0), 32'd1);
        if (eq[g].size() != 0) begin
          mon_e = eq[g].pop_front();
          chk("tx_byte", 32'(txb[g]), 32'(mon_e[7:0]));
          chk("grant_at_dv", 32'(gnt[g]), 32'(mon_e[11:8]));
        end
        if (g == 1) begin
          if (gap_armed) chk("dv_gap", cyc - rise_cyc[1], 32'd2);
          gap_armed = 1'b1;
        end
        if (!busy[g]) begin
          busy[g] = 1'b1;
          cap[g] = txb[g];
          cnt_m[g] = 0;
          act[g] = 1'b1;
        end
      end
      for (int k = 0; k < 4; k++) begin
        if (hs[g][k] && rq[g*4+k].size() != 0) void'(rq[g*4+k].pop_front());
        if (rq[g*4+k].size() != 0) begin
          rv[g][k] = 1'b1;
          rd[g][k*8 +: 8] = rq[g*4+k][0][7:0];
          rl[g][k] = rq[g*4+k][0][8];
        end else begin
          rv[g][k] = 1'b0;
          rl[g][k] = 1'b0;
        end
      end
    end
  end

  initial begin
    int d0, d1, a0, n;
    repeat (3) @(negedge clk);
    chk("rst_dv", 32'(dv), 32'd0);
    chk("rst_byte", 32'(txb[0]), 32'd0);
    chk("rst_grant", 32'(gnt[0]), 32'd0);
    chk("rst_abort", 32'(abt), 32'd0);
    chk("rst_ready", 32'(rr[0]), 32'd0);
    rst = 1'b0;

    // All four requesters at once: strict rotation from requester 0.
    for (int k = 0; k < 4; k++) begin
      exp_tx(0, 4'(1 << k), 8'(8'hA0 + k));
      exp_tx(0, 4'(1 << k), 8'(8'h40 + k));
      send(0, k, 8'(8'h40 + k), 1'b1);
    end
    wait_idle(0, 400, "idle_rotation");

    // Only 1 and 3 request again.
    exp_tx(0, 4'b0010, 8'hA1); exp_tx(0, 4'b0010, 8'h51);
    exp_tx(0, 4'b1000, 8'hA3); exp_tx(0, 4'b1000, 8'h53);
    send(0, 1, 8'h51, 1'b1);
    send(0, 3, 8'h53, 1'b1);
    wait_idle(0, 200, "idle_subset");

    // Two-byte packet from requester 2, and a headerless 3-byte packet on instance 1.
    d0 = dv_cnt[0];
    d1 = dv_cnt[1];
    exp_tx(0, 4'b0100, 8'hA2); exp_tx(0, 4'b0100, 8'h11); exp_tx(0, 4'b0100, 8'h22);
    send(0, 2, 8'h11, 1'b0);
    send(0, 2, 8'h22, 1'b1);
    exp_tx(1, 4'b1000, 8'hFF); exp_tx(1, 4'b1000, 8'h00); exp_tx(1, 4'b1000, 8'h5A);
    send(1, 3, 8'hFF, 1'b0);
    send(1, 3, 8'h00, 1'b0);
    send(1, 3, 8'h5A, 1'b1);
    wait_idle(0, 200, "idle_pkt_req2");
    wait_idle(1, 200, "idle_nohdr");
    chk("dv_count_req2", 32'(dv_cnt[0] - d0), 32'd3);
    chk("dv_count_nohdr", 32'(dv_cnt[1] - d1), 32'd3);

    // Requester 0 stalls after one byte; requester 1 is waiting.
    a0 = abort_cnt[0];
    exp_tx(0, 4'b0001, 8'hA0); exp_tx(0, 4'b0001, 8'h55);
    exp_tx(0, 4'b0010, 8'hA1); exp_tx(0, 4'b0010, 8'h66);
    send(0, 0, 8'h55, 1'b0);
    send(0, 1, 8'h66, 1'b1);
    wait_idle(0, 1600, "idle_timeout");
    chk("abort_once", 32'(abort_cnt[0] - a0), 32'd1);
    chk("abort_gap", 32'(abort_gap), 32'd1025);

    // 16-byte packet: every byte exactly once despite the two-cycle done.
    exp_tx(0, 4'b0010, 8'hA1);
    for (int i = 0; i < 16; i++) begin
      exp_tx(0, 4'b0010, 8'(8'h80 + i));
      send(0, 1, 8'(8'h80 + i), 1'(i == 15));
    end
    wait_idle(0, 600, "idle_long_pkt");

    // Reset while the header byte is on the line.
    exp_tx(0, 4'b0100, 8'hA2);
    send(0, 2, 8'h77, 1'b0);
    send(0, 2, 8'h78, 1'b1);
    n = 0;
    while (n < 50 && act[0] !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    chk("wait_active", 32'(n < 50), 32'd1);
    repeat (2) @(negedge clk);
    send(0, 0, 8'h30, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_dv", 32'(dv[0]), 32'd0);
    chk("midrst_byte", 32'(txb[0]), 32'd0);
    chk("midrst_grant", 32'(gnt[0]), 32'd0);
    chk("midrst_abort", 32'(abt[0]), 32'd0);
    chk("midrst_ready", 32'(rr[0]), 32'd0);
    exp_tx(0, 4'b0001, 8'hA0); exp_tx(0, 4'b0001, 8'h30);
    exp_tx(0, 4'b0100, 8'hA2); exp_tx(0, 4'b0100, 8'h77); exp_tx(0, 4'b0100, 8'h78);
    @(negedge clk);
    rst = 1'b0;
    wait_idle(0, 300, "idle_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Packet-level round-robin scheduler that shares one `uart_tx` serializer between `NUM_REQ` byte-stream requesters. It grants the transmitter to one requester at a time and optionally prefixes each packet with a channel-ID header byte. It feeds bytes one at a time, pacing each on the serializer's done pulse. It sits directly in front of `uart_tx`, driving its `i_Tx_DV` and `i_Tx_Byte` and observing `o_Tx_Active` and `o_Tx_Done`.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `UART_DATA_WIDTH`, 8: byte width.
- `ID_HEADER`, 1: 1 = send header byte `HEADER_BASE | id` before each packet; 0 = no header.
- `HEADER_BASE`, 8'hA0: header constant; low 3 bits must be 0.
- `TIMEOUT`, 1024: LOAD-state idle cycles before the grant is revoked; 0 disables. Counter is 16 bits.

Ports:
- `i_Clock`  in  1  — sole clock.
- `i_Reset`  in  1  — asynchronous, active-high reset.
- `i_Req_Valid`  in  NUM_REQ  — byte available, per requester.
- `i_Req_Data`  in  NUM_REQ*8  — requester k drives bits [8k+7:8k].
- `i_Req_Last`  in  NUM_REQ  — the current byte ends the packet.
- `o_Req_Ready`  out  NUM_REQ  — byte accepted this cycle (combinational).
- `o_Tx_DV`  out  1  — one-cycle pulse to `uart_tx` `i_Tx_DV`.
- `o_Tx_Byte`  out  8  — to `uart_tx` `i_Tx_Byte`; held stable from the DV pulse until done.
- `i_Tx_Active`  in  1  — from `uart_tx` `o_Tx_Active`.
- `i_Tx_Done`  in  1  — from `uart_tx` `o_Tx_Done`; high for 2 cycles per byte.
- `o_Grant`  out  NUM_REQ  — one-hot current owner; 0 when unowned.
- `o_Abort`  out  1  — one-cycle pulse when a grant is revoked by timeout.

## Operation
- Reset values: state IDLE, `o_Tx_DV`=0, `o_Tx_Byte`=0, `o_Grant`=0, `o_Abort`=0, round-robin pointer=NUM_REQ-1 (requester 0 wins first), `done_q`=0.
- Done detection: `done_rise = i_Tx_Done & ~done_q`. Exactly one rise counts per byte; the second done cycle is ignored.
- IDLE: leave when `i_Tx_Active`=0, `i_Tx_Done`=0 and any `i_Req_Valid` is set. This guards against a serializer still mid-byte after reset. Go to ARB.
- ARB (1 cycle): the winner is the first valid requester searching from pointer+1 upward, with wrap. Register `o_Grant`. Go to HDR if `ID_HEADER`, else LOAD.
- HDR: `o_Tx_Byte` <= `HEADER_BASE | id`, pulse `o_Tx_DV`, set `last_q`=0, go to WAIT.
- LOAD: `o_Req_Ready[g]` = `i_Req_Valid[g]`. When the handshake completes, capture data into `o_Tx_Byte` and `i_Req_Last[g]` into `last_q`, pulse `o_Tx_DV` next cycle, clear the timeout counter and go to WAIT.
  - If no valid byte arrives for `TIMEOUT` consecutive cycles: pulse `o_Abort`, set pointer=g, clear `o_Grant`, go to IDLE.
- WAIT: `o_Tx_DV` is low. On `done_rise`:
  - `last_q`=1: pointer=g, `o_Grant`=0, go to IDLE.
  - otherwise go to LOAD.
- Non-granted requesters always see `o_Req_Ready`=0; their valid may change freely.
- A packet is never interleaved with another; the grant changes only in ARB, on last byte, on timeout, or on reset.
- Reset mid-packet returns to IDLE. The in-flight byte (if any) completes on the line but is not re-issued.

## Timing
- The `o_Tx_DV` pulse is exactly 1 cycle and is only asserted while `uart_tx` is in its idle state (guaranteed by IDLE gating and `done_rise` pacing).
- Byte-to-byte gap: `done_rise` at cycle t → LOAD at t+1 (ready if valid) → DV at t+2.
- Packet-to-packet turnaround: last `done_rise` → IDLE → ARB → HDR DV, at least 3 cycles plus the wait for `i_Tx_Done` to drop.
- Simultaneous valid on all requesters: strict rotation, one packet each.
- `i_Req_Valid` low during ARB selection: that requester is skipped.

## Structure
- Package `uart_sched_pkg`: state enum (IDLE, ARB, HDR, LOAD, WAIT), `HEADER_BASE` default, timeout counter width.
- Sub-module `uart_rr_arbiter`: combinational rotate-priority-encoder taking request vector and pointer, returning one-hot grant and index. The pointer register stays in the scheduler.

## Test plan
- Single packet from requester 2: bytes 0x11, 0x22 (last) with `ID_HEADER`=1 → line carries A2, 11, 22. `o_Grant`=4'b0100 throughout, then 0. Exactly 3 DV pulses.
- All 4 requesters valid with 1-byte packets 0x40..0x43 → order 0,1,2,3 with headers A0..A3. Re-request 1 and 3 only → 1 then 3.
- Requester 0 drops valid for 1024 cycles after its first byte → `o_Abort` pulses once, `o_Grant`=0. Requester 1 (waiting) is granted next.
- `ID_HEADER`=0, requester 3 sends 0xFF, 0x00, 0x5A with last on 0x5A → three DV pulses, each exactly 1 cycle after a `done_rise` plus 1. `o_Tx_Byte` is stable from each DV until its done.
- Assert `i_Reset` while `uart_tx` is mid-data-bit → outputs return to reset values immediately. No DV is issued until `i_Tx_Active` and `i_Tx_Done` are both 0, after which requester 0 is served first.
- Hold `i_Tx_Done` high for 2 cycles per byte → each byte is counted once (no skipped or duplicated bytes over a 16-byte packet).
